// File: rtl/reflet_mmio_timer_pkg.sv
// Shared definitions for the Reflet MMIO timer: register word offsets,
// CTRL/STATUS bit positions and the run/idle state encoding.
package reflet_mmio_timer_pkg;

  typedef enum logic [2:0] {
    TIMER_CTRL     = 3'd0,
    TIMER_RELOAD   = 3'd1,
    TIMER_COUNT    = 3'd2,
    TIMER_STATUS   = 3'd3,
    TIMER_PRESCALE = 3'd4
  } timer_reg_e;

  localparam int unsigned TIMER_NUM_REGS = 5;

  localparam int unsigned CTRL_RUN         = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;

  localparam int unsigned STATUS_EXPIRED = 0;

  // CTRL.run is the timer state: IDLE while clear, RUNNING while set
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } timer_state_e;

endpackage

// File: rtl/reflet_prescaler.sv
// Prescale counter for the MMIO timer: emits a one-cycle tick every
// prescale_i+1 enabled cycles while running.
module reflet_prescaler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] prescale_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tick_o = run_i && (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reflet_mmio_timer.sv
// Memory-mapped prescaled down-counter with auto-reload, sticky expiry flag
// and level interrupt, responding on the Reflet external memory bus.
module reflet_mmio_timer
  import reflet_mmio_timer_pkg::*;
#(
  parameter int                   wordsize  = 16,
  parameter logic [wordsize-1:0]  base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  output logic [wordsize-1:0] data_out,
  input  logic                write_en,
  output logic                irq
);

  localparam int unsigned STRIDE = wordsize / 8;
  localparam int unsigned SHIFT  = $clog2(STRIDE);

  timer_state_e        state_q, state_d;
  logic                auto_q, auto_d;
  logic                irq_en_q, irq_en_d;
  logic                expired_q, expired_d;
  logic [wordsize-1:0] reload_q, reload_d;
  logic [wordsize-1:0] count_q, count_d;
  logic [wordsize-1:0] prescale_q, prescale_d;
  logic [wordsize-1:0] data_out_q, data_out_d;

  logic [wordsize-1:0] offset;
  logic                in_range, aligned, sel;
  timer_reg_e          reg_idx;
  logic                wr, wr_ctrl, wr_reload, wr_count, wr_status, wr_prescale;
  logic                run_start, tick, expire;

  // Decode against the offset so base_addr+5*stride never overflows
  assign offset   = addr - base_addr;
  assign in_range = (addr >= base_addr) &&
                    (offset < wordsize'(TIMER_NUM_REGS * STRIDE));
  assign aligned  = (addr[SHIFT-1:0] == '0);
  assign sel      = in_range && aligned;
  assign reg_idx  = timer_reg_e'(offset[SHIFT+2:SHIFT]);

  assign wr          = enable && write_en && sel;
  assign wr_ctrl     = wr && (reg_idx == TIMER_CTRL);
  assign wr_reload   = wr && (reg_idx == TIMER_RELOAD);
  assign wr_count    = wr && (reg_idx == TIMER_COUNT);
  assign wr_status   = wr && (reg_idx == TIMER_STATUS);
  assign wr_prescale = wr && (reg_idx == TIMER_PRESCALE);

  assign run_start = wr_ctrl && data_in[CTRL_RUN] && (state_q == ST_IDLE);

  reflet_prescaler #(
    .WIDTH (wordsize)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (reset),
    .en_i       (enable),
    .run_i      (state_q == ST_RUNNING),
    .clear_i    (run_start),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    expired_d  = expired_q;
    reload_d   = reload_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    expire     = 1'b0;

    case (state_q)
      ST_IDLE: begin
      end
      ST_RUNNING: begin
        if (tick) begin
          if (count_q > wordsize'(1)) begin
            count_d = count_q - wordsize'(1);
          end else begin
            expire = 1'b1;
            if (auto_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CPU writes land after the tick update so they override it
    if (wr_ctrl) begin
      state_d  = data_in[CTRL_RUN] ? ST_RUNNING : ST_IDLE;
      auto_d   = data_in[CTRL_AUTO_RELOAD];
      irq_en_d = data_in[CTRL_IRQ_EN];
    end
    if (wr_reload)   reload_d   = data_in;
    if (wr_count)    count_d    = data_in;
    if (wr_prescale) prescale_d = data_in;

    // Expiry set takes priority over a simultaneous write-1-to-clear
    if (wr_status && data_in[STATUS_EXPIRED]) expired_d = 1'b0;
    if (expire)                                expired_d = 1'b1;
  end

  always_comb begin
    data_out_d = '0;
    if (sel) begin
      case (reg_idx)
        TIMER_CTRL: begin
          data_out_d[CTRL_RUN]         = (state_q == ST_RUNNING);
          data_out_d[CTRL_AUTO_RELOAD] = auto_q;
          data_out_d[CTRL_IRQ_EN]      = irq_en_q;
        end
        TIMER_RELOAD:   data_out_d = reload_q;
        TIMER_COUNT:    data_out_d = count_q;
        TIMER_STATUS:   data_out_d[STATUS_EXPIRED] = expired_q;
        TIMER_PRESCALE: data_out_d = prescale_q;
        default:        data_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      reload_q   <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      data_out_q <= '0;
    end else if (enable) begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      expired_q  <= expired_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign irq      = expired_q && irq_en_q;

endmodule

// File: tb/tb_reflet_mmio_timer.sv
// Scoreboard bench for reflet_mmio_timer: the driver queues expected bus
// read data / irq levels by cycle; a monitor compares after each clock edge.
module tb_reflet_mmio_timer;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        enable   = 1'b1;
  logic        write_en = 1'b0;
  logic [15:0] addr     = 16'h0000;
  logic [15:0] data_in  = 16'h0000;
  logic [15:0] data_out;
  logic        irq;

  always #5 clk = ~clk;

  reflet_mmio_timer #(
    .wordsize  (16),
    .base_addr (16'hFF00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .write_en (write_en),
    .irq      (irq)
  );

  localparam logic [15:0] A_CTRL   = 16'hFF00;
  localparam logic [15:0] A_RELOAD = 16'hFF02;
  localparam logic [15:0] A_COUNT  = 16'hFF04;
  localparam logic [15:0] A_STATUS = 16'hFF06;
  localparam logic [15:0] A_PRESC  = 16'hFF08;

  int cyc    = 0;
  int total  = 0;
  int passed = 0;
  int p      = 0;

  int          due_q[$];
  bit          irq_q[$];
  logic [15:0] exp_q[$];
  string       name_q[$];

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic void push(int due, bit is_irq, logic [15:0] exp, string nm);
    due_q.push_back(due);
    irq_q.push_back(is_irq);
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endfunction

  // Monitor: compares every queued expectation that falls due at this edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < due_q.size(); ) begin
      if (due_q[i] <= cyc) begin
        if (irq_q[i]) chk(name_q[i], {15'b0, irq}, exp_q[i]);
        else          chk(name_q[i], data_out, exp_q[i]);
        due_q.delete(i);
        irq_q.delete(i);
        exp_q.delete(i);
        name_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b0; addr = a;
    push(cyc + 1, 1'b0, exp, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b1; write_en = 1'b0; addr = 16'h0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oneshot_cnt[8];
    int auto_cnt[6];
    int hold_cnt[5];
    oneshot_cnt = '{3, 3, 2, 2, 1, 1, 0, 0};
    auto_cnt    = '{2, 1, 2, 1, 2, 1};
    hold_cnt    = '{10, 10, 10, 9, 9};

    // Reset state and address decode
    repeat (3) @(negedge clk);
    chk("reset_dout", data_out, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    reset = 1'b1;
    rd(A_COUNT, 16'h0000, "reset_count");
    wr(A_RELOAD, 16'hABCD);
    rd(A_RELOAD, 16'hABCD, "reload_rw");
    rd(16'hFF03, 16'h0000, "misaligned_rd");
    rd(16'hFF0A, 16'h0000, "out_of_range_rd");
    rd(16'hFEFE, 16'h0000, "below_base_rd");
    wr(16'hFF03, 16'h1234);
    rd(A_RELOAD, 16'hABCD, "misaligned_wr_ignored");
    wr(16'hFF01, 16'hFFFF);
    rd(A_CTRL, 16'h0000, "misaligned_ctrl_ignored");
    wr(A_CTRL, 16'hFFF2);
    rd(A_CTRL, 16'h0002, "ctrl_mask");
    wr(A_CTRL, 16'h0000);

    // One-shot: expiry 6 cycles after the run-setting edge
    wr(A_RELOAD, 16'd3);
    wr(A_COUNT, 16'd3);
    wr(A_PRESC, 16'd1);
    wr(A_CTRL, 16'h0005);
    p = cyc + 1;
    for (int j = 0; j < 8; j++) begin
      rd(A_COUNT, 16'(oneshot_cnt[j]), "oneshot_count");
      push(cyc + 1, 1'b1, (j + 1 >= 6) ? 16'd1 : 16'd0, "oneshot_irq");
    end
    rd(A_CTRL, 16'h0004, "oneshot_run_cleared");
    rd(A_STATUS, 16'h0001, "oneshot_expired");

    // Write-1-to-clear drops irq on the next edge
    wr(A_STATUS, 16'h0001);
    push(cyc + 1, 1'b1, 16'd0, "clear_irq");
    rd(A_STATUS, 16'h0000, "clear_status");

    // Auto-reload with PRESCALE=0: expiry on every second edge
    wr(A_RELOAD, 16'd2);
    wr(A_COUNT, 16'd2);
    wr(A_PRESC, 16'd0);
    wr(A_CTRL, 16'h0007);
    p = cyc + 1;
    for (int j = 0; j < 6; j++) begin
      rd(A_COUNT, 16'(auto_cnt[j]), "auto_count");
      push(cyc + 1, 1'b1, (j == 0) ? 16'd0 : 16'd1, "auto_irq");
    end
    wr(A_STATUS, 16'h0001);
    push(cyc + 1, 1'b1, 16'd0, "w1c_non_expiry_edge");
    wr(A_STATUS, 16'h0001);
    push(cyc + 1, 1'b1, 16'd1, "w1c_on_expiry_edge");
    wr(A_COUNT, 16'h0050);
    rd(A_COUNT, 16'h0050, "count_write_wins");
    rd(A_COUNT, 16'h004F, "count_after_collision");

    // Enable low for 4 cycles mid-count: everything holds
    wr(A_CTRL, 16'h0000);
    wr(A_STATUS, 16'h0001);
    wr(A_PRESC, 16'd3);
    wr(A_COUNT, 16'd10);
    wr(A_CTRL, 16'h0001);
    p = cyc + 1;
    rd(A_COUNT, 16'd10, "hold_pre");
    repeat (4) begin
      @(negedge clk);
      enable = 1'b0; write_en = 1'b1; addr = A_RELOAD; data_in = 16'h1111;
      push(cyc + 1, 1'b0, 16'd10, "hold_dout");
    end
    for (int j = 0; j < 5; j++) rd(A_COUNT, 16'(hold_cnt[j]), "hold_count");
    rd(A_RELOAD, 16'd2, "hold_write_ignored");

    // Async reset mid-run
    wr(A_CTRL, 16'h0000);
    wr(A_PRESC, 16'd0);
    wr(A_RELOAD, 16'd5);
    wr(A_COUNT, 16'd1);
    wr(A_CTRL, 16'h0007);
    rd(A_COUNT, 16'd1, "prereset_count0");
    push(cyc + 1, 1'b1, 16'd1, "prereset_irq");
    rd(A_COUNT, 16'd5, "prereset_count1");
    rd(A_COUNT, 16'd4, "prereset_count2");
    @(negedge clk);
    write_en = 1'b0; addr = A_COUNT;
    #1 reset = 1'b0;
    #1;
    chk("async_reset_dout", data_out, 16'h0000);
    chk("async_reset_irq", {15'b0, irq}, 16'h0000);
    #1 reset = 1'b1;
    push(cyc + 1, 1'b0, 16'h0000, "postreset_count");
    rd(A_CTRL, 16'h0000, "postreset_ctrl");
    rd(A_STATUS, 16'h0000, "postreset_status");
    idle(4);
    rd(A_COUNT, 16'h0000, "postreset_no_ticks");
    push(cyc + 1, 1'b1, 16'd0, "postreset_irq");

    // Drain with a bounded wait
    for (int k = 0; k < 20 && due_q.size() > 0; k++) idle(1);
    while (due_q.size() > 0) begin
      total++;
      $display("FAIL %s: no result, expected %h", name_q[0], exp_q[0]);
      due_q.delete(0);
      irq_q.delete(0);
      exp_q.delete(0);
      name_q.delete(0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
